// File: rtl/sipo_frame_rx.sv
// Serial-to-parallel frame receiver: start bit, WIDTH data bits LSB first, stop bit, one-entry valid/ready buffer.
// Optional even-parity bit between data and stop is compiled in with `define SIPO_FRAME_RX_PARITY_EN.
module sipo_frame_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Din,
  output logic [WIDTH-1:0] Dout,
  output logic             valid,
  input  logic             ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
`ifdef SIPO_FRAME_RX_PARITY_EN
    S_PARITY = 2'd3,
`endif
    S_STOP   = 2'd2
  } state_t;

  localparam logic [5:0] LAST_BIT = 6'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;
  logic             r_frame_err;
  logic             r_parity_err;
  logic             r_overrun;
  logic [WIDTH-1:0] w_shift_next;
  logic             w_last;
  logic             w_par_bad;
  logic             w_load;
  logic             w_overrun;
  logic             w_frame_err;
  logic             w_par_err;

  assign w_shift_next = WIDTH'({Din, r_shift} >> 1);
  assign w_last       = (r_cnt == LAST_BIT);

`ifdef SIPO_FRAME_RX_PARITY_EN
  logic r_par_bad;

  function automatic logic even_parity(input logic [WIDTH-1:0] data);
    return ^data;
  endfunction

  // Parity verdict latched in PARITY, consumed at the stop edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_bad <= 1'b0;
    end else if (r_state == S_PARITY) begin
      r_par_bad <= Din ^ even_parity(r_shift);
    end else begin
      r_par_bad <= r_par_bad;
    end
  end

  assign w_par_bad = r_par_bad;
`else
  assign w_par_bad = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a low line in IDLE always starts a frame
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!Din) w_next = S_DATA;
        else      w_next = S_IDLE;
      end
      S_DATA: begin
`ifdef SIPO_FRAME_RX_PARITY_EN
        if (w_last) w_next = S_PARITY;
        else        w_next = S_DATA;
`else
        if (w_last) w_next = S_STOP;
        else        w_next = S_DATA;
`endif
      end
`ifdef SIPO_FRAME_RX_PARITY_EN
      S_PARITY: w_next = S_STOP;
`endif
      S_STOP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Stop-edge decode; a good frame loads if the buffer is empty or draining now
  always_comb begin
    w_load      = 1'b0;
    w_overrun   = 1'b0;
    w_frame_err = 1'b0;
    w_par_err   = 1'b0;
    if (r_state == S_STOP) begin
      w_frame_err = !Din;
      w_par_err   = w_par_bad;
      if (Din && !w_par_bad) begin
        if (!r_valid || ready) w_load    = 1'b1;
        else                   w_overrun = 1'b1;
      end else begin
        w_load    = 1'b0;
        w_overrun = 1'b0;
      end
    end else begin
      w_frame_err = 1'b0;
      w_par_err   = 1'b0;
    end
  end

  // Shift register and bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= 6'd0;
    end else if (r_state == S_DATA) begin
      r_shift <= w_shift_next;
      r_cnt   <= r_cnt + 6'd1;
    end else if (r_state == S_IDLE) begin
      r_shift <= r_shift;
      r_cnt   <= 6'd0;
    end else begin
      r_shift <= r_shift;
      r_cnt   <= r_cnt;
    end
  end

  // Output buffer, handshake and registered status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_dout       <= w_load ? r_shift : r_dout;
      r_valid      <= w_load | (r_valid & ~ready);
      r_frame_err  <= w_frame_err;
      r_parity_err <= w_par_err;
      r_overrun    <= w_overrun;
    end
  end

  assign Dout       = r_dout;
  assign valid      = r_valid;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Self-checking bench for sipo_frame_rx: directed scenarios plus randomized frames against a frame-level model.
module tb_sipo_frame_rx;

  localparam int W = 8;
`ifdef SIPO_FRAME_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         Din;
  logic         ready;
  logic [W-1:0] Dout;
  logic         valid;
  logic         frame_err;
  logic         parity_err;
  logic         overrun;

  int checks = 0;
  int errors = 0;

  // Frame-level model of the one-entry buffer
  logic [W-1:0] m_dout;
  logic         m_valid;

  sipo_frame_rx #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .Din(Din), .Dout(Dout), .valid(valid),
    .ready(ready), .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic din, input logic rdy);
    Din = din;
    ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Sends one frame and compares every output after every edge
  task automatic send_frame(input string tag, input logic [W-1:0] data, input logic stopb,
                            input logic par_flip, input int rdy_mode);
    logic bits[$];
    logic rdy, drain, full, good, last, e_fe, e_pe, e_ov;
    bits.push_back(1'b0);
    for (int i = 0; i < W; i++) bits.push_back(data[i]);
    if (PAR) bits.push_back((^data) ^ par_flip);
    bits.push_back(stopb);
    for (int i = 0; i < bits.size(); i++) begin
      last = (i == bits.size() - 1);
      case (rdy_mode)
        0:       rdy = 1'b0;
        1:       rdy = 1'b1;
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = last;
      endcase
      drain = m_valid && rdy;
      full  = m_valid && !drain;
      good  = last && stopb && !(PAR && par_flip);
      e_fe  = last && !stopb;
      e_pe  = last && PAR && par_flip;
      e_ov  = good && full;
      tick(bits[i], rdy);
      if (good && !full) begin
        m_dout  = data;
        m_valid = 1'b1;
      end else if (drain) begin
        m_valid = 1'b0;
      end
      checks++;
      if (valid !== m_valid) begin errors++; $display("FAIL %s valid bit%0d got %b exp %b", tag, i, valid, m_valid); end
      checks++;
      if (Dout !== m_dout) begin errors++; $display("FAIL %s Dout bit%0d got %h exp %h", tag, i, Dout, m_dout); end
      checks++;
      if (frame_err !== e_fe) begin errors++; $display("FAIL %s frame_err bit%0d got %b exp %b", tag, i, frame_err, e_fe); end
      checks++;
      if (parity_err !== e_pe) begin errors++; $display("FAIL %s parity_err bit%0d got %b exp %b", tag, i, parity_err, e_pe); end
      checks++;
      if (overrun !== e_ov) begin errors++; $display("FAIL %s overrun bit%0d got %b exp %b", tag, i, overrun, e_ov); end
    end
  endtask

  // Idle line (Din=1) for n cycles, checking drain behaviour and quiet status
  task automatic idle_cycles(input string tag, input int n, input int rdy_mode);
    logic rdy;
    for (int i = 0; i < n; i++) begin
      case (rdy_mode)
        0:       rdy = 1'b0;
        1:       rdy = 1'b1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (m_valid && rdy) m_valid = 1'b0;
      tick(1'b1, rdy);
      checks++;
      if (valid !== m_valid) begin errors++; $display("FAIL %s idle valid got %b exp %b", tag, valid, m_valid); end
      checks++;
      if (Dout !== m_dout) begin errors++; $display("FAIL %s idle Dout got %h exp %h", tag, Dout, m_dout); end
      checks++;
      if ({frame_err, parity_err, overrun} !== 3'b000) begin
        errors++; $display("FAIL %s idle pulses got %b exp 000", tag, {frame_err, parity_err, overrun});
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    Din = 1'b1;
    ready = 1'b0;
    m_valid = 1'b0;
    m_dout = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({Dout, valid, frame_err, parity_err, overrun} !== {W'(0), 4'b0000}) begin
      errors++; $display("FAIL reset outputs got Dout=%h v=%b fe=%b pe=%b ov=%b exp all 0",
                         Dout, valid, frame_err, parity_err, overrun);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_cycles("reset_idle", 2, 1);
  endtask

  task automatic test_single_frame();
    send_frame("single_a5", 8'hA5, 1'b1, 1'b0, 1);
    idle_cycles("single_drain", 1, 1);
    idle_cycles("single_idle", 2, 0);
  endtask

  task automatic test_back_to_back();
    send_frame("b2b_a5", 8'hA5, 1'b1, 1'b0, 1);
    send_frame("b2b_3c", 8'h3C, 1'b1, 1'b0, 1);
    idle_cycles("b2b_drain", 2, 1);
  endtask

  task automatic test_frame_err();
    send_frame("ferr_good", 8'h77, 1'b1, 1'b0, 1);
    idle_cycles("ferr_drain", 1, 1);
    send_frame("ferr_5a", 8'h5A, 1'b0, 1'b0, 1);
    // Stuck-low line: consecutive all-zero frames, each ending in frame_err
    send_frame("stuck_low0", 8'h00, 1'b0, 1'b0, 0);
    send_frame("stuck_low1", 8'h00, 1'b0, 1'b0, 0);
    idle_cycles("ferr_idle", 2, 1);
  endtask

  task automatic test_overrun();
    send_frame("ovr_11", 8'h11, 1'b1, 1'b0, 0);
    send_frame("ovr_22", 8'h22, 1'b1, 1'b0, 0);
    idle_cycles("ovr_hold", 1, 0);
    send_frame("ovr_33", 8'h33, 1'b1, 1'b0, 3);
    idle_cycles("ovr_drain", 2, 1);
  endtask

  task automatic test_reset_mid_frame();
    send_frame("rmf_buf", 8'h96, 1'b1, 1'b0, 0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    rst = 1'b1;
    #2;
    checks++;
    if ({Dout, valid, frame_err, parity_err, overrun} !== {W'(0), 4'b0000}) begin
      errors++; $display("FAIL reset_mid outputs got Dout=%h v=%b fe=%b pe=%b ov=%b exp all 0",
                         Dout, valid, frame_err, parity_err, overrun);
    end
    Din = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    Din = 1'b1;
    checks++;
    if ({Dout, valid} !== {W'(0), 1'b0}) begin
      errors++; $display("FAIL reset_mid held got Dout=%h v=%b exp 0", Dout, valid);
    end
    #3;
    rst = 1'b0;
    m_valid = 1'b0;
    m_dout = '0;
    idle_cycles("rmf_idle", 2, 1);
    send_frame("rmf_c3", 8'hC3, 1'b1, 1'b0, 1);
    idle_cycles("rmf_drain", 1, 1);
  endtask

`ifdef SIPO_FRAME_RX_PARITY_EN
  task automatic test_parity();
    send_frame("par_ok", 8'hA5, 1'b1, 1'b0, 1);
    idle_cycles("par_drain", 1, 1);
    send_frame("par_bad", 8'hA5, 1'b1, 1'b1, 1);
    send_frame("par_bad_ferr", 8'h0F, 1'b0, 1'b1, 1);
    idle_cycles("par_idle", 2, 1);
  endtask
`endif

  task automatic test_random();
    logic [W-1:0] d;
    logic         sb;
    logic         pf;
    for (int n = 0; n < 40; n++) begin
      d  = W'($urandom);
      sb = ($urandom_range(0, 5) != 0);
      pf = PAR && ($urandom_range(0, 4) == 0);
      send_frame("random", d, sb, pf, int'($urandom_range(0, 3)));
      idle_cycles("random_gap", int'($urandom_range(0, 2)), 2);
    end
    idle_cycles("random_end", 2, 1);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_frame_err();
    test_overrun();
    test_reset_mid_frame();
`ifdef SIPO_FRAME_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
